wave_scan_ctrl: RTL and testbench

Run-time sequencer for the three-channel waveform generator (sine/triangle/square LUT datapath on the VGA pixel clock).
- Decides when the shared phase index advances, frame-locked rather than driven by a free-running clock divider.
- Provides run/pause/single-step control, user speed selection and per-channel enables.
- Applies all user changes only at frame boundaries, so the display never tears mid-frame.
- Sits between the debounced key-pulse logic and the waveform generator / pixel mux.

---
 rtl/wave_pkg.sv | 49 ++++
 rtl/wave_phase_div.sv | 69 ++++++
 rtl/wave_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_wave_scan_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared constants, FSM encoding and small helpers for the waveform scan sequencer.
// Module parameters of the same names default to the values held here.
package wave_pkg;

   localparam int TABLE_SIZE    = 255;
   localparam int MAX_SPEED     = 7;
   localparam int DEFAULT_SPEED = 7;

   localparam int NUM_CH  = 3;
   localparam int CH_SINE = 0;
   localparam int CH_TRI  = 1;
   localparam int CH_SQR  = 2;

   localparam logic [NUM_CH-1:0] CH_ALL_ON =
      NUM_CH'((1 << CH_SINE) | (1 << CH_TRI) | (1 << CH_SQR));

   localparam logic [1:0] ST_RUN       = 2'd0;
   localparam logic [1:0] ST_PAUSE     = 2'd1;
   localparam logic [1:0] ST_STEP_PEND = 2'd2;

   typedef struct packed {
      logic              run;
      logic              step;
      logic              faster;
      logic              slower;
      logic [NUM_CH-1:0] ch_tog;
   } key_pulse_t;

   // Opposing speed keys in the same cycle cancel out.
   function automatic logic [2:0] speed_adjust(input logic [2:0] cur,
                                               input logic       up,
                                               input logic       dn,
                                               input logic [2:0] top);
      logic [2:0] nxt;
      nxt = cur;
      if (up && !dn && (cur < top)) begin
         nxt = cur + 3'd1;
      end else if (dn && !up && (cur != 3'd0)) begin
         nxt = cur - 3'd1;
      end
      return nxt;
   endfunction

   function automatic logic [7:0] phase_next(input logic [7:0] cur,
                                             input logic [7:0] last);
      return (cur == last) ? 8'd0 : cur + 8'd1;
   endfunction

endpackage

// File: rtl/wave_phase_div.sv
// Frame divider plus wrapping phase counter; advances either when the divider
// expires on an advance request or unconditionally on a forced step.
module wave_phase_div #(
   parameter int TABLE_SIZE = wave_pkg::TABLE_SIZE,
   parameter int MAX_SPEED  = wave_pkg::MAX_SPEED
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       advance_req,
   input  logic       force_step,
   input  logic       clear_cnt,
   input  logic [2:0] speed,
   output logic [7:0] phase_index,
   output logic       phase_wrap
);
   import wave_pkg::*;

   localparam int               CNT_W   = MAX_SPEED + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [2:0]       SPD_MAX = 3'(MAX_SPEED);
   localparam logic [7:0]       PH_LAST = 8'(TABLE_SIZE - 1);

   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] div_m1;
   logic [7:0]       phase_q, phase_d;
   logic             wrap_q, wrap_d;
   logic             do_step;

   always_comb begin
      div_m1      = (CNT_ONE << (SPD_MAX - speed)) - CNT_ONE;
      frame_cnt_d = frame_cnt_q;
      do_step     = force_step;

      if (clear_cnt) begin
         frame_cnt_d = '0;
      end else if (advance_req) begin
         // >= so that a speed-up with a large residual count fires at once
         if (frame_cnt_q >= div_m1) begin
            do_step     = 1'b1;
            frame_cnt_d = '0;
         end else begin
            frame_cnt_d = frame_cnt_q + CNT_ONE;
         end
      end

      phase_d = phase_q;
      wrap_d  = 1'b0;
      if (do_step) begin
         phase_d = phase_next(phase_q, PH_LAST);
         wrap_d  = (phase_q == PH_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         phase_q     <= 8'd0;
         wrap_q      <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         phase_q     <= phase_d;
         wrap_q      <= wrap_d;
      end
   end

   assign phase_index = phase_q;
   assign phase_wrap  = wrap_q;

endmodule

// File: rtl/wave_scan_ctrl.sv
// Run/pause/step sequencer for the waveform generator. User changes collect in
// pending registers and only become active on frame_start, so frames never tear.
module wave_scan_ctrl #(
   parameter int TABLE_SIZE    = wave_pkg::TABLE_SIZE,
   parameter int MAX_SPEED     = wave_pkg::MAX_SPEED,
   parameter int DEFAULT_SPEED = wave_pkg::DEFAULT_SPEED,
   parameter int START_RUN     = 1
) (
   input  logic       vga_clk,
   input  logic       sys_rstn,
   input  logic       frame_start,
   input  logic       key_run,
   input  logic       key_step,
   input  logic       key_faster,
   input  logic       key_slower,
   input  logic [2:0] key_ch_tog,
   output logic [7:0] phase_index,
   output logic [2:0] ch_en,
   output logic [2:0] speed,
   output logic       running,
   output logic       phase_wrap
);
   import wave_pkg::*;

   localparam logic [2:0] SPD_MAX  = 3'(MAX_SPEED);
   localparam logic [2:0] SPD_DEF  = 3'(DEFAULT_SPEED);
   localparam logic [1:0] ST_RESET = (START_RUN != 0) ? ST_RUN : ST_PAUSE;

   key_pulse_t keys;
   assign keys = {key_run, key_step, key_faster, key_slower, key_ch_tog};

   logic [1:0] state_q, state_d;
   logic [2:0] speed_q, speed_d;
   logic [2:0] speed_pend_q, speed_pend_d;
   logic [2:0] ch_en_q, ch_en_d;
   logic [2:0] ch_en_pend_q, ch_en_pend_d;
   logic       advance_req;
   logic       force_step;
   logic       clear_cnt;

   always_comb begin
      state_d     = state_q;
      advance_req = 1'b0;
      force_step  = 1'b0;
      clear_cnt   = 1'b0;
      case (state_q)
         ST_RUN: begin
            advance_req = frame_start;
            if (keys.run) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (keys.run) begin
               state_d   = ST_RUN;
               clear_cnt = 1'b1;
            end else if (keys.step) begin
               state_d = ST_STEP_PEND;
            end
         end
         ST_STEP_PEND: begin
            // The step still happens if run arrives with the frame pulse.
            force_step = frame_start;
            if (keys.run) begin
               state_d = ST_RUN;
            end else if (frame_start) begin
               state_d = ST_PAUSE;
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   always_comb begin
      speed_pend_d = speed_adjust(speed_pend_q, keys.faster, keys.slower, SPD_MAX);
      ch_en_pend_d = ch_en_pend_q ^ keys.ch_tog;
      speed_d      = speed_q;
      ch_en_d      = ch_en_q;
      if (frame_start) begin
         speed_d = speed_pend_q;
         ch_en_d = ch_en_pend_q;
      end
   end

   always_ff @(posedge vga_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_q      <= ST_RESET;
         speed_q      <= SPD_DEF;
         speed_pend_q <= SPD_DEF;
         ch_en_q      <= CH_ALL_ON;
         ch_en_pend_q <= CH_ALL_ON;
      end else begin
         state_q      <= state_d;
         speed_q      <= speed_d;
         speed_pend_q <= speed_pend_d;
         ch_en_q      <= ch_en_d;
         ch_en_pend_q <= ch_en_pend_d;
      end
   end

   wave_phase_div #(
      .TABLE_SIZE (TABLE_SIZE),
      .MAX_SPEED  (MAX_SPEED)
   ) u_phase_div (
      .clk         (vga_clk),
      .rst_n       (sys_rstn),
      .advance_req (advance_req),
      .force_step  (force_step),
      .clear_cnt   (clear_cnt),
      .speed       (speed_q),
      .phase_index (phase_index),
      .phase_wrap  (phase_wrap)
   );

   assign ch_en   = ch_en_q;
   assign speed   = speed_q;
   assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_wave_scan_ctrl.sv
// Table-driven bench for wave_scan_ctrl: expected outputs are queued as each
// cycle is driven and popped when the outputs are sampled on the falling edge.
module tb_wave_scan_ctrl;

   logic       vga_clk     = 1'b0;
   logic       sys_rstn    = 1'b0;
   logic       frame_start = 1'b0;
   logic       key_run     = 1'b0;
   logic       key_step    = 1'b0;
   logic       key_faster  = 1'b0;
   logic       key_slower  = 1'b0;
   logic [2:0] key_ch_tog  = 3'b000;
   logic [7:0] phase_index;
   logic [2:0] ch_en;
   logic [2:0] speed;
   logic       running;
   logic       phase_wrap;

   always #5 vga_clk = ~vga_clk;

   wave_scan_ctrl dut (
      .vga_clk     (vga_clk),
      .sys_rstn    (sys_rstn),
      .frame_start (frame_start),
      .key_run     (key_run),
      .key_step    (key_step),
      .key_faster  (key_faster),
      .key_slower  (key_slower),
      .key_ch_tog  (key_ch_tog),
      .phase_index (phase_index),
      .ch_en       (ch_en),
      .speed       (speed),
      .running     (running),
      .phase_wrap  (phase_wrap)
   );

   typedef struct {
      string      name;
      logic       fs;
      logic       run;
      logic       step;
      logic       fast;
      logic       slow;
      logic [2:0] tog;
      logic [7:0] ph;
      logic [2:0] ch;
      logic [2:0] spd;
      logic       rn;
      logic       wr;
   } vec_t;

   typedef struct packed {
      logic [7:0] ph;
      logic [2:0] ch;
      logic [2:0] spd;
      logic       rn;
      logic       wr;
   } obs_t;

   obs_t exp_q[$];
   vec_t tbl_a[$];
   vec_t tbl_b[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(input string name, input logic fs, input logic run,
                               input logic step, input logic fast, input logic slow,
                               input logic [2:0] tog, input logic [7:0] ph,
                               input logic [2:0] ch, input logic [2:0] spd,
                               input logic rn, input logic wr);
      vec_t v;
      v.name = name; v.fs = fs; v.run = run; v.step = step; v.fast = fast;
      v.slow = slow; v.tog = tog; v.ph = ph; v.ch = ch; v.spd = spd;
      v.rn = rn; v.wr = wr;
      return v;
   endfunction

   task automatic push_exp(input logic [7:0] ph, input logic [2:0] ch,
                           input logic [2:0] spd, input logic rn, input logic wr);
      obs_t e;
      e.ph = ph; e.ch = ch; e.spd = spd; e.rn = rn; e.wr = wr;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name);
      obs_t act;
      obs_t exp;
      act.ph = phase_index; act.ch = ch_en; act.spd = speed;
      act.rn = running;     act.wr = phase_wrap;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: no expected entry queued, actual ph=%0d ch=%b spd=%0d run=%b wrap=%b",
                  name, act.ph, act.ch, act.spd, act.rn, act.wr);
         return;
      end
      exp = exp_q.pop_front();
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual ph=%0d ch=%b spd=%0d run=%b wrap=%b, required ph=%0d ch=%b spd=%0d run=%b wrap=%b",
                  name, act.ph, act.ch, act.spd, act.rn, act.wr,
                  exp.ph, exp.ch, exp.spd, exp.rn, exp.wr);
      end else begin
         $display("ok   %s: ph=%0d ch=%b spd=%0d run=%b wrap=%b",
                  name, act.ph, act.ch, act.spd, act.rn, act.wr);
      end
   endtask

   // Drive one cycle of inputs (called just after a falling edge), then sample.
   task automatic apply(input vec_t v);
      frame_start = v.fs;
      key_run     = v.run;
      key_step    = v.step;
      key_faster  = v.fast;
      key_slower  = v.slow;
      key_ch_tog  = v.tog;
      push_exp(v.ph, v.ch, v.spd, v.rn, v.wr);
      @(posedge vga_clk);
      @(negedge vga_clk);
      frame_start = 1'b0;
      key_run     = 1'b0;
      key_step    = 1'b0;
      key_faster  = 1'b0;
      key_slower  = 1'b0;
      key_ch_tog  = 3'b000;
      check(v.name);
   endtask

   initial begin
      // name, fs,run,step,fast,slow,tog, ph,ch,spd,rn,wr
      tbl_a.push_back(mk("idle_after_reset", 0,0,0,0,0,3'b000, 8'd0, 3'b111,3'd7,1,0));
      tbl_a.push_back(mk("fs1",              1,0,0,0,0,3'b000, 8'd1, 3'b111,3'd7,1,0));
      tbl_a.push_back(mk("idle_hold",        0,0,0,0,0,3'b000, 8'd1, 3'b111,3'd7,1,0));
      tbl_a.push_back(mk("fs2",              1,0,0,0,0,3'b000, 8'd2, 3'b111,3'd7,1,0));
      tbl_a.push_back(mk("fs3",              1,0,0,0,0,3'b000, 8'd3, 3'b111,3'd7,1,0));
      tbl_a.push_back(mk("slower1",          0,0,0,0,1,3'b000, 8'd3, 3'b111,3'd7,1,0));
      tbl_a.push_back(mk("speed_not_yet",    0,0,0,0,0,3'b000, 8'd3, 3'b111,3'd7,1,0));
      tbl_a.push_back(mk("slower2",          0,0,0,0,1,3'b000, 8'd3, 3'b111,3'd7,1,0));
      tbl_a.push_back(mk("fs_activate_spd5", 1,0,0,0,0,3'b000, 8'd4, 3'b111,3'd5,1,0));
      tbl_a.push_back(mk("div4_cnt1",        1,0,0,0,0,3'b000, 8'd4, 3'b111,3'd5,1,0));
      tbl_a.push_back(mk("div4_cnt2",        1,0,0,0,0,3'b000, 8'd4, 3'b111,3'd5,1,0));
      tbl_a.push_back(mk("div4_cnt3",        1,0,0,0,0,3'b000, 8'd4, 3'b111,3'd5,1,0));
      tbl_a.push_back(mk("div4_advance",     1,0,0,0,0,3'b000, 8'd5, 3'b111,3'd5,1,0));
      tbl_a.push_back(mk("tog_with_fs",      1,0,0,0,0,3'b001, 8'd5, 3'b111,3'd5,1,0));
      tbl_a.push_back(mk("tog_activates",    1,0,0,0,0,3'b000, 8'd5, 3'b110,3'd5,1,0));
      tbl_a.push_back(mk("fast_and_slow",    0,0,0,1,1,3'b000, 8'd5, 3'b110,3'd5,1,0));
      tbl_a.push_back(mk("fs_spd_kept_5",    1,0,0,0,0,3'b000, 8'd5, 3'b110,3'd5,1,0));
      tbl_a.push_back(mk("div4_advance_2",   1,0,0,0,0,3'b000, 8'd6, 3'b110,3'd5,1,0));
      for (int i = 0; i < 5; i++)
         tbl_a.push_back(mk("faster_sat",    0,0,0,1,0,3'b000, 8'd6, 3'b110,3'd5,1,0));
      tbl_a.push_back(mk("fs_activate_spd7", 1,0,0,0,0,3'b000, 8'd6, 3'b110,3'd7,1,0));
      tbl_a.push_back(mk("ge_divider_fires", 1,0,0,0,0,3'b000, 8'd7, 3'b110,3'd7,1,0));

      tbl_b.push_back(mk("pause",            0,1,0,0,0,3'b000, 8'd0, 3'b110,3'd7,0,0));
      for (int i = 0; i < 5; i++)
         tbl_b.push_back(mk("paused_fs",     1,0,0,0,0,3'b000, 8'd0, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("step_req",         0,0,1,0,0,3'b000, 8'd0, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("step_fs",          1,0,0,0,0,3'b000, 8'd1, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("after_step_fs",    1,0,0,0,0,3'b000, 8'd1, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("run_beats_step",   0,1,1,0,0,3'b000, 8'd1, 3'b110,3'd7,1,0));
      tbl_b.push_back(mk("resumed_fs",       1,0,0,0,0,3'b000, 8'd2, 3'b110,3'd7,1,0));
      tbl_b.push_back(mk("step_in_run",      0,0,1,0,0,3'b000, 8'd2, 3'b110,3'd7,1,0));
      tbl_b.push_back(mk("pause2",           0,1,0,0,0,3'b000, 8'd2, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("paused_fs2",       1,0,0,0,0,3'b000, 8'd2, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("step_req2",        0,0,1,0,0,3'b000, 8'd2, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("step_in_pend",     0,0,1,0,0,3'b000, 8'd2, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("run_with_step_fs", 1,1,0,0,0,3'b000, 8'd3, 3'b110,3'd7,1,0));
      tbl_b.push_back(mk("pause3",           0,1,0,0,0,3'b000, 8'd3, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("step_req3",        0,0,1,0,0,3'b000, 8'd3, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("run_cancels_step", 0,1,0,0,0,3'b000, 8'd3, 3'b110,3'd7,1,0));
      tbl_b.push_back(mk("run_fs",           1,0,0,0,0,3'b000, 8'd4, 3'b110,3'd7,1,0));
      tbl_b.push_back(mk("pause4",           0,1,0,0,0,3'b000, 8'd4, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("step_req4",        0,0,1,0,0,3'b000, 8'd4, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("pend_slower",      0,0,0,0,1,3'b000, 8'd4, 3'b110,3'd7,0,0));
      tbl_b.push_back(mk("pend_tog",         0,0,0,0,0,3'b010, 8'd4, 3'b110,3'd7,0,0));

      // Reset held
      repeat (2) @(negedge vga_clk);
      push_exp(8'd0, 3'b111, 3'd7, 1'b1, 1'b0);
      check("reset_values");
      sys_rstn = 1'b1;

      foreach (tbl_a[i]) apply(tbl_a[i]);

      // Run phase up to TABLE_SIZE-1, then the wrap frame and one idle cycle.
      for (int p = 8; p <= 254; p++)
         apply(mk($sformatf("run_to_%0d", p), 1,0,0,0,0,3'b000, 8'(p), 3'b110,3'd7,1,0));
      apply(mk("wrap_to_0",   1,0,0,0,0,3'b000, 8'd0, 3'b110,3'd7,1,1));
      apply(mk("wrap_pulse_1cyc", 0,0,0,0,0,3'b000, 8'd0, 3'b110,3'd7,1,0));

      foreach (tbl_b[i]) apply(tbl_b[i]);

      // Asynchronous reset while in STEP_PEND with pending edits outstanding.
      #2 sys_rstn = 1'b0;
      #1;
      push_exp(8'd0, 3'b111, 3'd7, 1'b1, 1'b0);
      check("async_reset_immediate");
      @(posedge vga_clk);
      @(negedge vga_clk);
      push_exp(8'd0, 3'b111, 3'd7, 1'b1, 1'b0);
      check("reset_held_over_edge");
      sys_rstn = 1'b1;
      apply(mk("post_reset_fs",   1,0,0,0,0,3'b000, 8'd1, 3'b111,3'd7,1,0));
      apply(mk("post_reset_idle", 0,0,0,0,0,3'b000, 8'd1, 3'b111,3'd7,1,0));

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
